// File: rtl/baby_ctrl_pkg.sv
// baby_ctrl_pkg: shared state encoding and widths for the Baby run controller
package baby_ctrl_pkg;
  typedef enum logic [1:0] {
    STOP   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_t;
  localparam int EXEC_CNT_W = 4;
endpackage

// File: rtl/baby_run_controller_key_edge_detect.sv
// key_edge_detect: one-shot rising-edge detector for a console key, sampled on tick cycles
module key_edge_detect (
  input  logic s_clock,
  input  logic reset,
  input  logic tick,
  input  logic key_in,
  output logic edge_out
);
  logic prev;
  // remember the key level only on tick cycles so edges seen between ticks are not lost
  always_ff @(posedge s_clock or posedge reset)
    if (reset) prev <= 1'b0;
    else if (tick) prev <= key_in;
  assign edge_out = key_in & ~prev;
endmodule

// File: rtl/baby_run_controller.sv
// baby_run_controller: fetch/decode/execute sequencer with run/stop/step control; `BABY_INSTR_COUNTER_EN adds instr_count
module baby_run_controller
  import baby_ctrl_pkg::*;
#(
  parameter int EXEC_CYCLES = 1
) (
  input  logic reset,
  input  logic s_clock,
  input  logic tick,
  input  logic run_key,
  input  logic stop_key,
  input  logic step_key,
  input  logic halt_req,
  output logic phase_fetch,
  output logic phase_decode,
  output logic phase_exec,
  output logic instr_done,
  output logic running,
  output logic stopped
`ifdef BABY_INSTR_COUNTER_EN
  ,
  output logic [15:0] instr_count
`endif
);
  localparam logic [EXEC_CNT_W-1:0] LAST = EXEC_CNT_W'(EXEC_CYCLES - 1);
  state_t state, state_next;
  logic [EXEC_CNT_W-1:0] exec_cnt;
  logic run_edge, stop_edge, step_edge;
  logic latch, latch_next, step_pend;
  key_edge_detect u_run (.s_clock(s_clock), .reset(reset), .tick(tick), .key_in(run_key), .edge_out(run_edge));
  key_edge_detect u_stop (.s_clock(s_clock), .reset(reset), .tick(tick), .key_in(stop_key), .edge_out(stop_edge));
  key_edge_detect u_step (.s_clock(s_clock), .reset(reset), .tick(tick), .key_in(step_key), .edge_out(step_edge));
  // run latch: clear side (stop key or STP at instruction end) dominates the run key
  assign latch_next = (latch | run_edge) & ~(stop_edge | (halt_req & instr_done));
  // state register, advancing only on tick cycles
  always_ff @(posedge s_clock or posedge reset)
    if (reset) state <= STOP;
    else if (tick) state <= state_next;
  // next state: leave STOP on run or a pending step, stop only at an instruction boundary
  always_comb begin
    state_next = state;
    unique case (state)
      STOP:    state_next = (latch_next | step_pend) ? FETCH : STOP;
      FETCH:   state_next = DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = instr_done ? (latch_next ? FETCH : STOP) : EXEC;
      default: state_next = STOP;
    endcase
  end
  // one-hot phase outputs decoded from state and the exec counter
  always_comb begin
    phase_fetch  = state == FETCH;
    phase_decode = state == DECODE;
    phase_exec   = state == EXEC;
    stopped      = state == STOP;
    instr_done   = state == EXEC && exec_cnt == LAST;
    running      = latch;
  end
  // run latch, step request and exec cycle counter
  always_ff @(posedge s_clock or posedge reset)
    if (reset) begin
      latch     <= 1'b0;
      step_pend <= 1'b0;
      exec_cnt  <= '0;
    end else if (tick) begin
      latch     <= latch_next;
      step_pend <= (state == STOP && state_next == FETCH) ? 1'b0 :
                   (step_edge && state == STOP && !latch_next) ? 1'b1 : step_pend;
      exec_cnt  <= state == EXEC ? exec_cnt + 1'b1 : '0;
    end
`ifdef BABY_INSTR_COUNTER_EN
  // completed-instruction counter, wrapping at 16 bits
  always_ff @(posedge s_clock or posedge reset)
    if (reset) instr_count <= '0;
    else if (tick && instr_done) instr_count <= instr_count + 16'd1;
`endif
endmodule

// File: tb/tb_baby_run_controller.sv
// tb_baby_run_controller: randomized and directed checks of two controller instances (EXEC_CYCLES 1 and 3) against a position-based model
module tb_baby_run_controller;
  logic s_clock = 0, reset = 0, tick = 0;
  logic run_key = 0, stop_key = 0, step_key = 0, halt_req = 0;
  logic pf[2], pd[2], pe[2], idn[2], rn[2], st[2];
  logic [15:0] ic[2];
  int checks = 0, passes = 0;
  int m_pos[2];
  bit m_l[2], m_sp[2];
  int m_cnt[2];
  bit p_r, p_s, p_k;

  always #5 s_clock = ~s_clock;

  baby_run_controller #(.EXEC_CYCLES(1)) dut1 (
    .reset(reset), .s_clock(s_clock), .tick(tick), .run_key(run_key), .stop_key(stop_key),
    .step_key(step_key), .halt_req(halt_req), .phase_fetch(pf[0]), .phase_decode(pd[0]),
    .phase_exec(pe[0]), .instr_done(idn[0]), .running(rn[0]), .stopped(st[0])
`ifdef BABY_INSTR_COUNTER_EN
    , .instr_count(ic[0])
`endif
  );
  baby_run_controller #(.EXEC_CYCLES(3)) dut3 (
    .reset(reset), .s_clock(s_clock), .tick(tick), .run_key(run_key), .stop_key(stop_key),
    .step_key(step_key), .halt_req(halt_req), .phase_fetch(pf[1]), .phase_decode(pd[1]),
    .phase_exec(pe[1]), .instr_done(idn[1]), .running(rn[1]), .stopped(st[1])
`ifdef BABY_INSTR_COUNTER_EN
    , .instr_count(ic[1])
`endif
  );
`ifndef BABY_INSTR_COUNTER_EN
  assign ic[0] = 16'h0;
  assign ic[1] = 16'h0;
`endif

  // Model: m_pos is the position inside the current instruction (-1 stopped,
  // 0 fetch, 1 decode, 2..E+1 execute cycles); E+1 is the final execute cycle.
  function automatic int ecyc(int i);
    return i == 0 ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = -1; m_l[i] = 0; m_sp[i] = 0; m_cnt[i] = 0;
    end
    p_r = 0; p_s = 0; p_k = 0;
  endtask

  task automatic model_tick(int i);
    bit re, se, ke, done, nl;
    re = run_key & ~p_r; se = stop_key & ~p_s; ke = step_key & ~p_k;
    done = m_pos[i] == ecyc(i) + 1;
    nl = (m_l[i] | re) & ~(se | (halt_req & done));
    if (done) m_cnt[i] = (m_cnt[i] + 1) % 65536;
    if (m_pos[i] < 0) begin
      if (nl || m_sp[i]) begin m_pos[i] = 0; m_sp[i] = 0; end
      else if (ke) m_sp[i] = 1;
    end else if (done) m_pos[i] = nl ? 0 : -1;
    else m_pos[i]++;
    m_l[i] = nl;
  endtask

  function automatic logic [21:0] expv(int i);
    int p = m_pos[i];
    return {p == 0, p == 1, p >= 2, p == ecyc(i) + 1, m_l[i], p < 0,
`ifdef BABY_INSTR_COUNTER_EN
            16'(m_cnt[i])};
`else
            16'h0};
`endif
  endfunction

  function automatic logic [21:0] obs(int i);
    return {pf[i], pd[i], pe[i], idn[i], rn[i], st[i], ic[i]};
  endfunction

  task automatic step(input bit t, input bit r, input bit s, input bit k, input bit h);
    tick = t; run_key = r; stop_key = s; step_key = k; halt_req = h;
    @(posedge s_clock);
    if (reset) model_reset();
    else if (t) begin
      model_tick(0); model_tick(1);
      p_r = r; p_s = s; p_k = k;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; model_reset();
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick = 1; model_reset(); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pf[i], pd[i], pe[i], idn[i], rn[i], st[i]} !== 6'b000001)
        $display("FAIL reset_async inst=%0d got=%b exp=000001", i, {pf[i], pd[i], pe[i], idn[i], rn[i], st[i]});
      else passes++;
    end
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    reset = 0;
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (st[i] !== 1'b1 || obs(i) !== expv(i))
          $display("FAIL reset_idle inst=%0d cyc=%0d got=%b exp=%b", i, c, obs(i), expv(i));
        else passes++;
      end
    end
  endtask

  task automatic test_run();
    do_reset();
    step(1, 1, 0, 0, 0);
    for (int c = 0; c < 15; c++) begin
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL run inst=%0d cyc=%0d got=%b exp=%b", i, c, obs(i), expv(i));
        else passes++;
      end
      checks++;
      if (pf[0] !== (c % 3 == 2) || rn[0] !== 1'b1)
        $display("FAIL run_period3 cyc=%0d got fetch=%b run=%b exp fetch=%b run=1", c, pf[0], rn[0], c % 3 == 2);
      else passes++;
    end
  endtask

  task automatic test_step();
    int dones;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      dones = 0;
      step(1, 0, 0, 1, 0);
      for (int c = 0; c < 9; c++) begin
        step(1, 0, 0, 0, 0);
        dones += idn[1];
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (obs(i) !== expv(i) || rn[i] !== 1'b0)
            $display("FAIL step inst=%0d rep=%0d cyc=%0d got=%b exp=%b", i, rep, c, obs(i), expv(i));
          else passes++;
        end
      end
      checks++;
      if (dones != 1 || st[1] !== 1'b1)
        $display("FAIL step_once rep=%0d got dones=%0d stopped=%b exp dones=1 stopped=1", rep, dones, st[1]);
      else passes++;
    end
  endtask

  task automatic test_halt();
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    checks++;
    if (pe[1] !== 1'b1 || idn[1] !== 1'b1 || rn[1] !== 1'b1)
      $display("FAIL halt_early got exec=%b done=%b run=%b exp 1 1 1", pe[1], idn[1], rn[1]);
    else passes++;
    step(1, 0, 0, 0, 1);
    checks++;
    if (st[1] !== 1'b1 || rn[1] !== 1'b0)
      $display("FAIL halt_final got stopped=%b run=%b exp stopped=1 run=0", st[1], rn[1]);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== expv(i)) $display("FAIL halt_model inst=%0d got=%b exp=%b", i, obs(i), expv(i));
      else passes++;
    end
  endtask

  task automatic test_keys();
    do_reset();
    step(1, 1, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, 1, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (st[i] !== 1'b1 || rn[i] !== 1'b0 || obs(i) !== expv(i))
          $display("FAIL keys_simul inst=%0d cyc=%0d got=%b exp=%b", i, c, obs(i), expv(i));
        else passes++;
      end
    end
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL keys_midfetch inst=%0d cyc=%0d got=%b exp=%b", i, c, obs(i), expv(i));
        else passes++;
      end
    end
    checks++;
    if (st[1] !== 1'b1) $display("FAIL keys_boundary got stopped=%b exp=1", st[1]);
    else passes++;
  endtask

  task automatic test_random();
    bit r = 0, s = 0, k = 0, h;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 9) == 0) r = ~r;
      if ($urandom_range(0, 14) == 0) s = ~s;
      if ($urandom_range(0, 5) == 0) k = ~k;
      h = $urandom_range(0, 5) == 0;
      step($urandom_range(0, 3) != 0, r, s, k, h);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) $display("FAIL random inst=%0d cyc=%0d got=%b exp=%b", i, c, obs(i), expv(i));
        else passes++;
      end
    end
  endtask

  task automatic test_tick_gate();
    logic [21:0] held[2];
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      step(1, n == 1, n == 16, 0, 0);
      held[0] = obs(0); held[1] = obs(1);
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== held[i] || obs(i) !== expv(i))
          $display("FAIL tick_gate inst=%0d n=%0d got=%b exp=%b", i, n, obs(i), expv(i));
        else passes++;
      end
    end
    checks++;
    if (st[0] !== 1'b1) $display("FAIL tick_gate_stop got stopped=%b exp=1", st[0]);
    else passes++;
`ifdef BABY_INSTR_COUNTER_EN
    checks++;
    if (ic[0] !== 16'd5) $display("FAIL instr_count got=%0d exp=5", ic[0]);
    else passes++;
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    reset = 1; model_reset(); #1;
    checks++;
    if (st[0] !== 1'b1 || pd[0] !== 1'b0 || ic[0] !== 16'd0)
      $display("FAIL reset_mid_decode got stopped=%b decode=%b count=%0d exp 1 0 0", st[0], pd[0], ic[0]);
    else passes++;
    step(1, 0, 0, 0, 0);
    reset = 0;
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_step();
    test_halt();
    test_keys();
    test_tick_gate();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/baby_run_controller.md
Name: baby_run_controller

Overview:
- Fetch/decode/execute phase sequencer and run/stop control for the Baby CPU datapath.
- Holds the machine run latch with set/reset semantics: run key sets it; stop key or a decoded STP instruction clears it.
- Emits one-hot phase enables that gate the datapath registers.
- Supports continuous run, single-step (one full instruction per step key press) and halt on STP.

Parameters:
- EXEC_CYCLES, 1, number of tick-enabled cycles spent in EXEC per instruction; legal range 1..15.

Ports:
- reset  input  1  asynchronous, active-high; forces every state element to its reset value.
- s_clock  input  1  system clock; all state updates on the rising edge.
- tick  input  1  clock enable; state updates only when tick=1 at the s_clock edge.
- run_key  input  1  level; a rising edge sets the run latch.
- stop_key  input  1  level; a rising edge clears the run latch.
- step_key  input  1  level; a rising edge requests a single instruction while stopped.
- halt_req  input  1  decoded STP instruction; sampled only in the final EXEC cycle.
- phase_fetch  output  1  high while state=FETCH.
- phase_decode  output  1  high while state=DECODE.
- phase_exec  output  1  high while state=EXEC.
- instr_done  output  1  high during the final EXEC cycle (combinational from state and counter).
- running  output  1  run latch.
- stopped  output  1  stop lamp; high while state=STOP.

Behaviour:
- Reset (async, dominant over everything):
  - state=STOP, run latch=0, step_pend=0, exec_cnt=0, key-history registers=0.
  - Resulting outputs: phase_*=0, running=0, instr_done=0, stopped=1.
- Key edge detection:
  - Each key's previous level is registered on tick-enabled cycles.
  - edge = key & ~prev. A key held high produces exactly one edge.
- Run latch update, on tick cycles:
  - next = (latch | run_edge) & ~(stop_edge | halt_taken).
  - The clear side dominates: simultaneous run and stop edges leave the latch at 0.
  - halt_taken = halt_req & instr_done.
- step_pend:
  - Set by step_edge only while state=STOP and the latch will be 0 next cycle.
  - Cleared on the STOP->FETCH transition.
  - step_edge while running is ignored.
- State machine (advances only when tick=1):
  - STOP -> FETCH if the next run latch=1 or step_pend=1; otherwise stay in STOP.
    - step_pend is a registered flag, so a step edge reaches FETCH 2 ticks later.
    - A run edge reaches FETCH 1 tick later.
  - FETCH -> DECODE, always 1 tick.
  - DECODE -> EXEC, always 1 tick; exec_cnt loads 0.
  - EXEC: exec_cnt increments each tick. When exec_cnt==EXEC_CYCLES-1 (instr_done=1):
    - go to FETCH if the next run latch=1;
    - otherwise go to STOP.
- Stop or halt mid-instruction: the current instruction always completes its EXEC phase; STOP is entered only at an instruction boundary.
- Single-step: exactly one FETCH, DECODE, EXEC sequence, then STOP. running stays 0 throughout.
- tick=0: all state holds and outputs are stable. Key edges are not lost: prev is updated only on tick cycles.
- Instruction latency in continuous run: 2+EXEC_CYCLES ticks.
- Exactly one of phase_fetch / phase_decode / phase_exec / stopped is high at all times.

Optional Feature:
- BABY_INSTR_COUNTER_EN.
- Defined:
  - Adds output instr_count [15:0].
  - Increments, wrapping at 0xFFFF->0x0000, on every tick cycle with instr_done=1.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package baby_ctrl_pkg:
  - state enum STOP=2'd0, FETCH=2'd1, DECODE=2'd2, EXEC=2'd3;
  - constant EXEC_CNT_W=4.
- One sub-module, key_edge_detect:
  - ports s_clock, reset, tick, key_in, edge_out;
  - instantiated three times, once per key.

Test Plan:
- Reset check: assert reset with tick=1 held.
  - Outputs: stopped=1, running=0, phase_*=0.
  - Release reset: the design stays in STOP indefinitely.
- Continuous run: EXEC_CYCLES=1, pulse run_key.
  - Next tick: FETCH, then DECODE, then EXEC, then FETCH repeating with period 3.
  - running=1 throughout.
- Single-step: pulse step_key while stopped.
  - Exactly one FETCH, DECODE, EXEC sequence with instr_done=1 once, then stopped=1.
  - running=0 throughout.
  - A second step_key pulse repeats the sequence.
- Halt on STP: while running with EXEC_CYCLES=3, assert halt_req.
  - halt_req in EXEC cycle 0 or 1 has no effect.
  - halt_req in EXEC cycle 2: the next state is STOP and running=0.
- Simultaneous keys: run_key and stop_key rise in the same tick while stopped.
  - Latch stays 0 and the design stays in STOP.
  - Mid-FETCH stop_key: the instruction completes through EXEC, then STOP.
- tick gating plus counter (macro defined):
  - Run 5 instructions with tick toggling 1,0,1,0.
  - Phases advance only on tick=1.
  - instr_count=5.
  - Async reset mid-DECODE: immediate STOP, instr_count=0.
